lcd_pattern_gen: RTL

Parametrised LCD test-pattern generator that replaces the fixed checkerboard source between the LCD timing driver and the RGB565 output path. It takes the driver's pixel coordinates and produces one RGB565 word per `lcd_clk`, selecting at frame boundaries between colour bars, a checkerboard with configurable cell size and colours, a solid colour, and a horizontally scrolling checkerboard. All cell and band arithmetic uses incremental counters; there are no runtime dividers.

---
 rtl/lcd_pattern_gen.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_pattern_gen.sv
// LCD test-pattern source: colour bars, checkerboard, solid colour and a scrolling checkerboard.
// Cell and band positions come from incremental counters advanced with the driver coordinates.
module lcd_pattern_gen #(
    parameter int          H_DISP      = 800,
    parameter int          V_DISP      = 480,
    parameter int          CELL_W      = 40,
    parameter int          CELL_H      = 40,
    parameter int          SCROLL_STEP = 2,
    parameter logic [15:0] FG_COLOR    = 16'hFFFF,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic        lcd_clk,
    input  logic        sys_rst,
    input  logic [10:0] pixel_xpos,
    input  logic [10:0] pixel_ypos,
    input  logic [1:0]  mode,
    input  logic [15:0] solid_color,
    output logic [15:0] pixel_data,
    output logic        frame_start,
    output logic [1:0]  active_mode
);

    localparam int BAND_H = V_DISP / 5;
    localparam int XW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int YW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int BW     = (BAND_H > 1) ? $clog2(BAND_H) : 1;
    localparam int SW     = $clog2(2 * CELL_W);
    localparam int SW1    = SW + 1;

    localparam logic [XW-1:0] X_LAST    = XW'(CELL_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(CELL_H - 1);
    localparam logic [BW-1:0] B_LAST    = BW'(BAND_H - 1);
    localparam logic [SW:0]   PERIOD    = SW1'(2 * CELL_W);
    localparam logic [SW:0]   STEP      = SW1'(SCROLL_STEP);
    localparam logic [SW-1:0] CELL_W_S  = SW'(CELL_W);
    localparam logic [11:0]   H_LIM     = 12'(H_DISP);
    localparam logic [2:0]    LAST_BAND = 3'd4;

    // frame-level state
    logic [10:0]   ypos_q, ypos_d;
    logic [1:0]    active_mode_q, active_mode_d;
    logic [15:0]   solid_q, solid_d;
    logic [SW-1:0] scroll_pos_q, scroll_pos_d;
    logic          frame_start_q, frame_start_d;

    // cell / band counters
    logic [XW-1:0] x_sub_q, x_sub_d;
    logic          x_par_q, x_par_d;
    logic [YW-1:0] y_sub_q, y_sub_d;
    logic          y_par_q, y_par_d;
    logic [BW-1:0] band_sub_q, band_sub_d;
    logic [2:0]    band_q, band_d;

    logic [15:0]   pixel_data_q, pixel_data_d;

    logic          boundary;
    logic          line_start;
    logic          row_change;
    logic          x_in_range;
    logic [SW:0]   scroll_sum;
    logic [SW-1:0] line_off;
    logic          checker_par;

    always_comb begin
        boundary   = (pixel_ypos == 11'd0) && (ypos_q != 11'd0);
        line_start = (pixel_xpos == 11'd0);
        row_change = (pixel_ypos != ypos_q);
        x_in_range = ({1'b0, pixel_xpos} < H_LIM);
        scroll_sum = {1'b0, scroll_pos_q} + STEP;

        active_mode_d = active_mode_q;
        solid_d       = solid_q;
        scroll_pos_d  = scroll_pos_q;
        if (boundary) begin
            active_mode_d = mode;
            solid_d       = solid_color;
            scroll_pos_d  = (scroll_sum >= PERIOD) ? SW'(scroll_sum - PERIOD) : SW'(scroll_sum);
        end
        frame_start_d = boundary;
        ypos_d        = pixel_ypos;
    end

    // The boundary pixel already uses the freshly latched mode and scroll offset.
    always_comb begin
        line_off = (active_mode_d == 2'd3) ? scroll_pos_d : '0;
        x_sub_d  = x_sub_q;
        x_par_d  = x_par_q;
        if (line_start) begin
            if (line_off >= CELL_W_S) begin
                x_sub_d = XW'(line_off - CELL_W_S);
                x_par_d = 1'b1;
            end else begin
                x_sub_d = XW'(line_off);
                x_par_d = 1'b0;
            end
        end else if (x_in_range) begin
            if (x_sub_q == X_LAST) begin
                x_sub_d = '0;
                x_par_d = ~x_par_q;
            end else begin
                x_sub_d = x_sub_q + XW'(1);
            end
        end
    end

    // Rows advance on a ypos change; the last bar band absorbs any leftover lines.
    always_comb begin
        y_sub_d    = y_sub_q;
        y_par_d    = y_par_q;
        band_sub_d = band_sub_q;
        band_d     = band_q;
        if (pixel_ypos == 11'd0) begin
            y_sub_d    = '0;
            y_par_d    = 1'b0;
            band_sub_d = '0;
            band_d     = 3'd0;
        end else if (row_change) begin
            if (y_sub_q == Y_LAST) begin
                y_sub_d = '0;
                y_par_d = ~y_par_q;
            end else begin
                y_sub_d = y_sub_q + YW'(1);
            end
            if (band_q != LAST_BAND) begin
                if (band_sub_q == B_LAST) begin
                    band_sub_d = '0;
                    band_d     = band_q + 3'd1;
                end else begin
                    band_sub_d = band_sub_q + BW'(1);
                end
            end
        end
    end

    always_comb begin
        checker_par  = x_par_d ^ y_par_d;
        pixel_data_d = checker_par ? FG_COLOR : BG_COLOR;
        case (active_mode_d)
            2'd0: begin
                case (band_d)
                    3'd0:    pixel_data_d = 16'hFFFF;
                    3'd1:    pixel_data_d = 16'h0000;
                    3'd2:    pixel_data_d = 16'hF800;
                    3'd3:    pixel_data_d = 16'h07E0;
                    default: pixel_data_d = 16'h001F;
                endcase
            end
            2'd2:    pixel_data_d = solid_d;
            default: pixel_data_d = checker_par ? FG_COLOR : BG_COLOR;
        endcase
    end

    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            ypos_q        <= '0;
            active_mode_q <= '0;
            solid_q       <= '0;
            scroll_pos_q  <= '0;
            frame_start_q <= 1'b0;
            x_sub_q       <= '0;
            x_par_q       <= 1'b0;
            y_sub_q       <= '0;
            y_par_q       <= 1'b0;
            band_sub_q    <= '0;
            band_q        <= '0;
            pixel_data_q  <= '0;
        end else begin
            ypos_q        <= ypos_d;
            active_mode_q <= active_mode_d;
            solid_q       <= solid_d;
            scroll_pos_q  <= scroll_pos_d;
            frame_start_q <= frame_start_d;
            x_sub_q       <= x_sub_d;
            x_par_q       <= x_par_d;
            y_sub_q       <= y_sub_d;
            y_par_q       <= y_par_d;
            band_sub_q    <= band_sub_d;
            band_q        <= band_d;
            pixel_data_q  <= pixel_data_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign frame_start = frame_start_q;
    assign active_mode = active_mode_q;

endmodule
